// File: rtl/riscv_pkg.sv
// Shared core types for the fetch stage: word widths, reset PC and the
// {pc, instr} entry carried through the fetch buffer.
package riscv_pkg;

   localparam int          XLEN             = 32;
   localparam int          ILEN             = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned; stray low address bits are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, execute redirect, halt and the
// decode-facing valid/ready head of the fetch buffer.
interface fetch_unit_if #(
   parameter int FIFO_DEPTH = 2
);
   import riscv_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0]  imem_addr;
   logic [ILEN-1:0]  imem_instr;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             halt;
   logic             out_valid;
   logic [XLEN-1:0]  out_pc;
   logic [ILEN-1:0]  out_instr;
   logic             out_ready;
   logic [CNT_W-1:0] fifo_count;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      input  halt,
      output out_valid,
      output out_pc,
      output out_instr,
      input  out_ready,
      output fifo_count
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      output halt,
      input  out_valid,
      input  out_pc,
      input  out_instr,
      output out_ready,
      input  fifo_count
   );

endinterface

// File: rtl/fetch_fifo.sv
// In-order fetch buffer of {pc, instr} entries with synchronous flush.
// Head is read straight from storage; there is no write-to-read bypass.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t wr_data,
   input  logic         pop,
   output fetch_entry_t rd_data,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = {PTR_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         // Simultaneous push and pop on a full buffer leaves the count unchanged.
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {$bits(fetch_entry_t){1'b0}};
         end
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word per cycle into the fetch
// buffer and reloads the PC on redirects from execute.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input logic           clk,
   input logic           rst_n,
   fetch_unit_if.master  bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] count_s;
   logic             out_valid_s;
   logic             pop_s;
   logic             push_s;
   fetch_entry_t     wr_entry_s;
   fetch_entry_t     head_s;

   // Redirect outranks everything: the head handshake in that cycle is void.
   always_comb begin
      out_valid_s = (count_s != CNT_W'(0));
      pop_s       = out_valid_s & bus.out_ready & ~bus.redirect_valid;
      push_s      = ~bus.halt & ~bus.redirect_valid
                    & ((count_s < CNT_W'(FIFO_DEPTH)) | pop_s);
      wr_entry_s.pc    = pc_q;
      wr_entry_s.instr = bus.imem_instr;
      if (bus.redirect_valid) begin
         pc_d = align_pc(bus.redirect_pc);
      end else if (push_s) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (bus.redirect_valid),
      .push    (push_s),
      .wr_data (wr_entry_s),
      .pop     (pop_s),
      .rd_data (head_s),
      .count   (count_s)
   );

   assign bus.imem_addr  = pc_q;
   assign bus.out_valid  = out_valid_s;
   assign bus.out_pc     = head_s.pc;
   assign bus.out_instr  = head_s.instr;
   assign bus.fifo_count = count_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural fetch model queues expected
// {pc, instr} entries as stimulus is applied; decode handshakes pop and compare.
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;

   fetch_entry_t exp_q[$];
   logic [31:0]  m_pc;

   fetch_unit_if #(.FIFO_DEPTH(DEPTH)) bus ();

   fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // addi x(idx+1), x0, idx  -> mem[0]=0x00000093, mem[1]=0x00100113, ...
   function automatic logic [31:0] imem_of(input logic [31:0] addr);
      logic [29:0] idx;
      logic [4:0]  rd;
      idx = addr[31:2];
      rd  = idx[4:0] + 5'd1;
      return {idx[11:0], 5'd0, 3'd0, rd, 7'h13};
   endfunction

   assign bus.imem_instr = imem_of(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, check state, advance the model, clock.
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic hlt, input logic rdy);
      logic         pop_m;
      logic         push_m;
      fetch_entry_t e;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.halt           = hlt;
      bus.out_ready      = rdy;
      #1;
      check_val("imem_addr", bus.imem_addr, m_pc);
      check_val("fifo_count", 32'(bus.fifo_count), 32'(exp_q.size()));
      check_val("out_valid", 32'(bus.out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
      pop_m  = (exp_q.size() != 0) && rdy && !rv;
      push_m = !hlt && !rv && ((exp_q.size() < DEPTH) || pop_m);
      if (pop_m) begin
         e = exp_q.pop_front();
         check_val("out_pc", bus.out_pc, e.pc);
         check_val("out_instr", bus.out_instr, e.instr);
      end
      if (rv) begin
         exp_q.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else if (push_m) begin
         e.pc    = m_pc;
         e.instr = imem_of(m_pc);
         exp_q.push_back(e);
         m_pc = m_pc + 32'd4;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check_val({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
      check_val({tag, "_addr"}, bus.imem_addr, RST_PC);
      check_val({tag, "_pc"}, bus.out_pc, 32'd0);
      check_val({tag, "_instr"}, bus.out_instr, 32'd0);
   endtask

   initial begin
      n_total            = 0;
      n_bad              = 0;
      m_pc               = RST_PC;
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.halt           = 1'b0;
      bus.out_ready      = 1'b0;
      #12;
      check_reset_state("reset");
      check_val("imem0", imem_of(32'd0), 32'h0000_0093);
      check_val("imem1", imem_of(32'd4), 32'h0010_0113);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming with decode always ready
      for (int i = 0; i < 7; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Decode stalls: buffer fills, PC stops
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Redirect on a full buffer with a simultaneous head handshake
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0040, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Misaligned target and PC wrap-around
      cycle(1'b1, 32'h0000_0043, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);
      cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Halt with a full buffer drains it, then fetch resumes at the held PC
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1);
      cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Asynchronous reset between edges
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      exp_q.delete();
      m_pc = RST_PC;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Random mix of redirects, halts and stalls
      for (int i = 0; i < 200; i++) begin
         logic        rv;
         logic [31:0] rpc;
         rv  = ($urandom_range(0, 9) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         cycle(rv, rpc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
